// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - default geometry and latency constants
//   - WEN encodings (write = 0, read = 1)
//   - responder FSM state type
package dmem_pkg;

  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 128;
  localparam int DEF_LATENCY = 2;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

  localparam logic WEN_WR = 1'b0;
  localparam logic WEN_RD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: SRAM-style data-memory port between the processor
// (master) and the memory responder (slave).
//   CEN   chip enable, active-low
//   WEN   0 = write, 1 = read
//   OEN   output enable, active-low (Q forced to 0 when high)
//   A     word address
//   D     write data
//   Q     read data
//   stall access outstanding; master holds its request while high
interface data_mem_responder_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              CEN;
  logic              WEN;
  logic              OEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] Q;
  logic              stall;

  modport master (output CEN, WEN, OEN, A, D, input Q, stall);
  modport slave  (input CEN, WEN, OEN, A, D, output Q, stall);

endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W word storage.
//   clk, rst_n  clock; asynchronous active-low clear of every word
//   we          synchronous write enable
//   waddr/wdata write port
//   raddr/rdata combinational read port
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Flop-based so the whole array can be cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: slave end of the processor's data-memory port with a
// fixed access latency, reported through stall.
//   clk, rst_n  clock; asynchronous active-low reset
//   bus         data_mem_responder_if.slave (CEN/WEN/OEN/A/D in, Q/stall out)
//
// state | meaning
// IDLE  | no access outstanding
// BUSY  | access accepted, latency counter running
// DONE  | access complete for one cycle
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY   // 1..15
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] a_lat;
  logic [DATA_W-1:0] d_lat;
  logic              wen_lat;
  logic [DATA_W-1:0] q_reg;
  logic [DATA_W-1:0] rd_data;
  logic              access_now;
  logic              mem_we;

  // Final BUSY edge with the request still held: the access happens here.
  assign access_now = (state == ST_BUSY) && !bus.CEN && (cnt == '0);
  assign mem_we     = access_now && (wen_lat == WEN_WR);

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (a_lat),
    .wdata (d_lat),
    .raddr (a_lat),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      a_lat   <= '0;
      d_lat   <= '0;
      wen_lat <= WEN_RD;
      q_reg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!bus.CEN) begin
            state   <= ST_BUSY;
            a_lat   <= bus.A;
            d_lat   <= bus.D;
            wen_lat <= bus.WEN;
            cnt     <= CNT_W'(LATENCY - 1);
          end
        end
        ST_BUSY: begin
          if (bus.CEN) begin
            // Request withdrawn: drop the access without touching memory or Q.
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            state <= ST_DONE;
            if (wen_lat == WEN_RD) begin
              q_reg <= rd_data;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          // The request still visible here is the one just served.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.stall = 1'b0;
    case (state)
      ST_IDLE: bus.stall = ~bus.CEN;
      ST_BUSY: bus.stall = 1'b1;
      ST_DONE: bus.stall = 1'b0;
      default: bus.stall = 1'b0;
    endcase
  end

  assign bus.Q = bus.OEN ? '0 : q_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of the data-memory responder at
// LATENCY 2 (main instance) and 1/4/15 (latency sweep instances).
module tb_data_mem_responder;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  data_mem_responder_if #(.ADDR_W(7), .DATA_W(32)) b2  ();
  data_mem_responder_if #(.ADDR_W(7), .DATA_W(32)) b1  ();
  data_mem_responder_if #(.ADDR_W(7), .DATA_W(32)) b4  ();
  data_mem_responder_if #(.ADDR_W(7), .DATA_W(32)) b15 ();

  data_mem_responder #(.ADDR_W(7), .DATA_W(32), .DEPTH(128), .LATENCY(2))
    dut2  (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  data_mem_responder #(.ADDR_W(7), .DATA_W(32), .DEPTH(128), .LATENCY(1))
    dut1  (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  data_mem_responder #(.ADDR_W(7), .DATA_W(32), .DEPTH(128), .LATENCY(4))
    dut4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  data_mem_responder #(.ADDR_W(7), .DATA_W(32), .DEPTH(128), .LATENCY(15))
    dut15 (.clk(clk), .rst_n(rst_n), .bus(b15.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one access on the LATENCY=2 instance. Returns the number of
  // stalled cycles and Q sampled in the first non-stalled (DONE) cycle.
  // Leaves time in the middle of that DONE cycle with CEN released.
  task automatic do_access(input logic wen, input logic [6:0] a,
                           input logic [31:0] d, output int stall_cycles,
                           output logic [31:0] q_done);
    int n;
    @(posedge clk); #1;
    b2.CEN = 1'b0; b2.WEN = wen; b2.A = a; b2.D = d;
    n = 0;
    q_done = 'x;
    while (n < 40) begin
      #4;
      if (b2.stall !== 1'b1) begin
        q_done = b2.Q;
        break;
      end
      n++;
      @(posedge clk); #1;
    end
    b2.CEN = 1'b1;
    if (n >= 40) begin
      tests_run++;
      tests_failed++;
      $display("FAIL access_timeout: stall still high after %0d cycles, required to drop", n);
    end
    stall_cycles = n;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (b2.Q !== 32'h0) begin
      tests_failed++; $display("FAIL reset_q: got %h expected %h", b2.Q, 32'h0);
    end
    tests_run++;
    if (b2.stall !== 1'b0) begin
      tests_failed++; $display("FAIL reset_stall_cen1: got %b expected 0", b2.stall);
    end
    b2.CEN = 1'b0;
    #1;
    tests_run++;
    if (b2.stall !== 1'b1) begin
      tests_failed++; $display("FAIL reset_stall_cen0: got %b expected 1", b2.stall);
    end
    b2.CEN = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  task automatic test_read_after_reset();
    int sc; logic [31:0] q;
    do_access(1'b1, 7'd5, 32'h0, sc, q);
    tests_run++;
    if (sc != 3) begin
      tests_failed++; $display("FAIL read5_stall_width: got %0d expected 3", sc);
    end
    tests_run++;
    if (q !== 32'h0) begin
      tests_failed++; $display("FAIL read5_q: got %h expected %h", q, 32'h0);
    end
  endtask

  task automatic test_write_read();
    int sc; logic [31:0] q;
    do_access(1'b0, 7'd127, 32'hDEADBEEF, sc, q);
    tests_run++;
    if (sc != 3) begin
      tests_failed++; $display("FAIL write127_stall_width: got %0d expected 3", sc);
    end
    tests_run++;
    if (q !== 32'h0) begin
      tests_failed++; $display("FAIL write127_q_unchanged: got %h expected %h", q, 32'h0);
    end
    do_access(1'b1, 7'd127, 32'h0, sc, q);
    tests_run++;
    if (sc != 3) begin
      tests_failed++; $display("FAIL read127_stall_width: got %0d expected 3", sc);
    end
    tests_run++;
    if (q !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL read127_q: got %h expected %h", q, 32'hDEADBEEF);
    end
  endtask

  task automatic test_oen();
    int sc; logic [31:0] q;
    do_access(1'b0, 7'd20, 32'h12345678, sc, q);
    do_access(1'b1, 7'd20, 32'h0, sc, q);
    tests_run++;
    if (q !== 32'h12345678) begin
      tests_failed++; $display("FAIL oen_read20: got %h expected %h", q, 32'h12345678);
    end
    b2.OEN = 1'b1; #1;
    tests_run++;
    if (b2.Q !== 32'h0) begin
      tests_failed++; $display("FAIL oen_high_q: got %h expected %h", b2.Q, 32'h0);
    end
    b2.OEN = 1'b0; #1;
    tests_run++;
    if (b2.Q !== 32'h12345678) begin
      tests_failed++; $display("FAIL oen_low_q: got %h expected %h", b2.Q, 32'h12345678);
    end
  endtask

  task automatic test_abort();
    int sc; logic [31:0] q;
    @(posedge clk); #1;
    b2.CEN = 1'b0; b2.WEN = 1'b0; b2.A = 7'd30; b2.D = 32'hCAFEF00D;
    @(posedge clk); #1;
    b2.CEN = 1'b1;
    #3;
    tests_run++;
    if (b2.stall !== 1'b1) begin
      tests_failed++; $display("FAIL abort_busy_stall: got %b expected 1", b2.stall);
    end
    @(posedge clk); #4;
    tests_run++;
    if (b2.stall !== 1'b0) begin
      tests_failed++; $display("FAIL abort_idle_stall: got %b expected 0", b2.stall);
    end
    tests_run++;
    if (b2.Q !== 32'h12345678) begin
      tests_failed++; $display("FAIL abort_q_kept: got %h expected %h", b2.Q, 32'h12345678);
    end
    do_access(1'b1, 7'd30, 32'h0, sc, q);
    tests_run++;
    if (q !== 32'h0) begin
      tests_failed++; $display("FAIL abort_no_write: got %h expected %h", q, 32'h0);
    end
  endtask

  task automatic test_reset_mid();
    int sc; logic [31:0] q;
    do_access(1'b1, 7'd20, 32'h0, sc, q);
    @(posedge clk); #1;
    b2.CEN = 1'b0; b2.WEN = 1'b0; b2.A = 7'd10; b2.D = 32'hFFFFFFFF;
    @(posedge clk); #1;
    #1;
    rst_n = 1'b0;
    b2.CEN = 1'b1;
    #1;
    tests_run++;
    if (b2.Q !== 32'h0) begin
      tests_failed++; $display("FAIL rstmid_q: got %h expected %h", b2.Q, 32'h0);
    end
    tests_run++;
    if (b2.stall !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_idle_stall: got %b expected 0", b2.stall);
    end
    #3;
    rst_n = 1'b1;
    do_access(1'b1, 7'd10, 32'h0, sc, q);
    tests_run++;
    if (q !== 32'h0) begin
      tests_failed++; $display("FAIL rstmid_read10: got %h expected %h", q, 32'h0);
    end
    do_access(1'b1, 7'd127, 32'h0, sc, q);
    tests_run++;
    if (q !== 32'h0) begin
      tests_failed++; $display("FAIL rstmid_read127_cleared: got %h expected %h", q, 32'h0);
    end
  endtask

  task automatic test_mid_change();
    int sc; int n; logic [31:0] q;
    @(posedge clk); #1;
    b2.CEN = 1'b0; b2.WEN = 1'b0; b2.A = 7'd3; b2.D = 32'hAAAA5555;
    @(posedge clk); #1;
    b2.A = 7'd4; b2.D = 32'h11112222;
    n = 0;
    while (n < 40) begin
      #4;
      if (b2.stall !== 1'b1) break;
      n++;
      @(posedge clk); #1;
    end
    b2.CEN = 1'b1;
    tests_run++;
    if (n != 2) begin
      tests_failed++; $display("FAIL midchg_remaining_stall: got %0d expected 2", n);
    end
    do_access(1'b1, 7'd3, 32'h0, sc, q);
    tests_run++;
    if (q !== 32'hAAAA5555) begin
      tests_failed++; $display("FAIL midchg_mem3: got %h expected %h", q, 32'hAAAA5555);
    end
    do_access(1'b1, 7'd4, 32'h0, sc, q);
    tests_run++;
    if (q !== 32'h0) begin
      tests_failed++; $display("FAIL midchg_mem4: got %h expected %h", q, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    int sc; int mis; logic [31:0] q; logic exp_s; logic [31:0] q_done;
    do_access(1'b0, 7'd21, 32'h5A5A5A5A, sc, q);
    @(posedge clk); #1;
    b2.CEN = 1'b0; b2.WEN = 1'b1; b2.A = 7'd21;
    mis = 0;
    q_done = 'x;
    for (int k = 0; k < 12; k++) begin
      #4;
      exp_s = ((k % 4) != 3);
      if (b2.stall !== exp_s) mis++;
      if (k == 3) q_done = b2.Q;
      @(posedge clk); #1;
    end
    b2.CEN = 1'b1;
    tests_run++;
    if (mis != 0) begin
      tests_failed++; $display("FAIL b2b_stall_pattern: got %0d mismatching cycles expected 0", mis);
    end
    tests_run++;
    if (q_done !== 32'h5A5A5A5A) begin
      tests_failed++; $display("FAIL b2b_done_q: got %h expected %h", q_done, 32'h5A5A5A5A);
    end
  endtask

  task automatic test_latency_sweep();
    int mis1, mis4, mis15, w1, w4, w15;
    mis1 = 0; mis4 = 0; mis15 = 0; w1 = -1; w4 = -1; w15 = -1;
    @(posedge clk); #1;
    b1.CEN = 1'b0;  b1.WEN = 1'b1;  b1.A = 7'd0;
    b4.CEN = 1'b0;  b4.WEN = 1'b1;  b4.A = 7'd0;
    b15.CEN = 1'b0; b15.WEN = 1'b1; b15.A = 7'd0;
    for (int k = 0; k < 40; k++) begin
      #4;
      if (b1.stall  !== ((k % 3)  != 2))  mis1++;
      if (b4.stall  !== ((k % 6)  != 5))  mis4++;
      if (b15.stall !== ((k % 17) != 16)) mis15++;
      if (b1.stall  === 1'b0 && w1  < 0) w1  = k;
      if (b4.stall  === 1'b0 && w4  < 0) w4  = k;
      if (b15.stall === 1'b0 && w15 < 0) w15 = k;
      @(posedge clk); #1;
    end
    b1.CEN = 1'b1; b4.CEN = 1'b1; b15.CEN = 1'b1;
    tests_run++;
    if (w1 != 2) begin
      tests_failed++; $display("FAIL lat1_stall_width: got %0d expected 2", w1);
    end
    tests_run++;
    if (w4 != 5) begin
      tests_failed++; $display("FAIL lat4_stall_width: got %0d expected 5", w4);
    end
    tests_run++;
    if (w15 != 16) begin
      tests_failed++; $display("FAIL lat15_stall_width: got %0d expected 16", w15);
    end
    tests_run++;
    if (mis1 != 0) begin
      tests_failed++; $display("FAIL lat1_pattern: got %0d mismatching cycles expected 0", mis1);
    end
    tests_run++;
    if (mis4 != 0) begin
      tests_failed++; $display("FAIL lat4_pattern: got %0d mismatching cycles expected 0", mis4);
    end
    tests_run++;
    if (mis15 != 0) begin
      tests_failed++; $display("FAIL lat15_pattern: got %0d mismatching cycles expected 0", mis15);
    end
  endtask

  task automatic test_lat1_data();
    logic [31:0] q;
    int n;
    @(posedge clk); #1;
    b1.CEN = 1'b0; b1.WEN = 1'b0; b1.A = 7'd7; b1.D = 32'h0F0F0F0F;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b1.CEN = 1'b1;                      // DONE cycle of the write
    @(posedge clk); #1;
    b1.CEN = 1'b0; b1.WEN = 1'b1; b1.A = 7'd7;
    n = 0;
    q = 'x;
    while (n < 40) begin
      #4;
      if (b1.stall !== 1'b1) begin
        q = b1.Q;
        break;
      end
      n++;
      @(posedge clk); #1;
    end
    b1.CEN = 1'b1;
    tests_run++;
    if (q !== 32'h0F0F0F0F) begin
      tests_failed++; $display("FAIL lat1_read7: got %h expected %h", q, 32'h0F0F0F0F);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    b2.CEN = 1'b1;  b2.WEN = 1'b1;  b2.OEN = 1'b0;  b2.A = '0;  b2.D = '0;
    b1.CEN = 1'b1;  b1.WEN = 1'b1;  b1.OEN = 1'b0;  b1.A = '0;  b1.D = '0;
    b4.CEN = 1'b1;  b4.WEN = 1'b1;  b4.OEN = 1'b0;  b4.A = '0;  b4.D = '0;
    b15.CEN = 1'b1; b15.WEN = 1'b1; b15.OEN = 1'b0; b15.A = '0; b15.D = '0;

    test_reset();
    test_read_after_reset();
    test_write_read();
    test_oen();
    test_abort();
    test_reset_mid();
    test_mid_change();
    test_back_to_back();
    test_latency_sweep();
    test_lat1_data();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
